// File: rtl/mem_access_stage_if.sv
// Data-cache request/grant/response port between the MEM stage (master) and the cache (slave).
interface mem_access_stage_if;
  logic        DC_REQ;
  logic        DC_WE;
  logic [31:0] DC_ADDR;
  logic [31:0] DC_WDATA;
  logic [3:0]  DC_BE;
  logic        DC_GNT;
  logic        DC_RVALID;
  logic [31:0] DC_RDATA;

  modport master (
    output DC_REQ, DC_WE, DC_ADDR, DC_WDATA, DC_BE,
    input  DC_GNT, DC_RVALID, DC_RDATA
  );

  modport slave (
    input  DC_REQ, DC_WE, DC_ADDR, DC_WDATA, DC_BE,
    output DC_GNT, DC_RVALID, DC_RDATA
  );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: loads/stores through a request/grant/response cache port, results to WB.
// Optional access watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
  parameter logic [5:0] OP_LB  = 6'b101000,
  parameter logic [5:0] OP_LBU = 6'b101001,
  parameter logic [5:0] OP_LH  = 6'b101010,
  parameter logic [5:0] OP_LHU = 6'b101011,
  parameter logic [5:0] OP_SB  = 6'b101100,
  parameter logic [5:0] OP_SH  = 6'b101101
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr_IN,
  input  logic [31:0] Instr_PC_IN,
  input  logic [31:0] ALU_result_IN,
  input  logic [5:0]  WriteRegister_IN,
  input  logic [31:0] MemWriteData_IN,
  input  logic        RegWrite_IN,
  input  logic        MemRead_IN,
  input  logic        MemWrite_IN,
  input  logic [5:0]  ALU_Control_IN,
  input  logic [31:0] Instr_UID_IN,
  output logic        STALL_OUT,
  output logic        READ_COMPLETE,
  mem_access_stage_if.master dc,
  output logic [31:0] Instr_OUT,
  output logic [31:0] Instr_PC_OUT,
  output logic [31:0] WriteData_OUT,
  output logic [5:0]  WriteRegister_OUT,
  output logic        RegWrite_OUT,
  output logic        Valid_OUT,
  output logic [31:0] Instr_UID_OUT,
  output logic        MEM_ERR
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      r_state;
  logic        w_memop, w_is_store, w_in_req;
  logic        w_ld_done, w_st_done, w_timeout, w_done;
  logic [1:0]  w_lane;

  function automatic logic f_is_byte(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
  endfunction

  function automatic logic f_is_half(input logic [5:0] op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  // Big-endian lanes: byte 0 lives in bits [31:24] and is enabled by DC_BE[3].
  function automatic logic [3:0] f_be(input logic [5:0] op, input logic [1:0] lane);
    if (f_is_byte(op))      return 4'b1000 >> lane;
    else if (f_is_half(op)) return lane[1] ? 4'b0011 : 4'b1100;
    else                    return 4'b1111;
  endfunction

  function automatic logic [31:0] f_wdata(input logic [5:0] op, input logic [31:0] wd);
    if (f_is_byte(op))      return {4{wd[7:0]}};
    else if (f_is_half(op)) return {2{wd[15:0]}};
    else                    return wd;
  endfunction

  function automatic logic [31:0] f_load(input logic [5:0] op, input logic [1:0] lane,
                                         input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = rd[31:24];
      2'd1:    b = rd[23:16];
      2'd2:    b = rd[15:8];
      default: b = rd[7:0];
    endcase
    h = lane[1] ? rd[15:0] : rd[31:16];
    if (op == OP_LB)       return {{24{b[7]}}, b};
    else if (op == OP_LBU) return {24'd0, b};
    else if (op == OP_LH)  return {{16{h[15]}}, h};
    else if (op == OP_LHU) return {16'd0, h};
    else                   return rd;
  endfunction

  assign w_memop    = MemRead_IN | MemWrite_IN;
  assign w_is_store = MemWrite_IN & ~MemRead_IN;
  assign w_in_req   = (r_state == REQ);
  assign w_lane     = ALU_result_IN[1:0];
  assign w_ld_done  = (r_state == WAIT) & dc.DC_RVALID;
  assign w_st_done  = w_in_req & dc.DC_GNT & w_is_store;
  assign w_done     = w_ld_done | w_st_done | w_timeout;

  assign READ_COMPLETE = w_done;
  // Gated by reset so every output reads 0 while reset is held.
  assign STALL_OUT     = RESET & (((r_state == IDLE) & w_memop) | (r_state != IDLE)) & ~w_done;

  assign dc.DC_REQ   = w_in_req;
  assign dc.DC_WE    = w_in_req & w_is_store;
  assign dc.DC_ADDR  = w_in_req ? {ALU_result_IN[31:2], 2'b00} : 32'd0;
  assign dc.DC_BE    = w_in_req ? f_be(ALU_Control_IN, w_lane) : 4'd0;
  assign dc.DC_WDATA = w_in_req ? f_wdata(ALU_Control_IN, MemWriteData_IN) : 32'd0;

`ifdef MEM_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        r_err;

  assign w_timeout = (r_state != IDLE) && (r_cnt == 16'(TIMEOUT_CYCLES - 1)) &&
                     !(w_ld_done || w_st_done);
  assign MEM_ERR   = r_err;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= ((r_state == IDLE) || w_done) ? 16'd0 : r_cnt + 16'd1;
      if (w_timeout) r_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign MEM_ERR   = 1'b0;
`endif

  // MEM -> WB register boundary
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state           <= IDLE;
      Instr_OUT         <= '0;
      Instr_PC_OUT      <= '0;
      WriteData_OUT     <= '0;
      WriteRegister_OUT <= '0;
      RegWrite_OUT      <= 1'b0;
      Valid_OUT         <= 1'b0;
      Instr_UID_OUT     <= '0;
    end else begin
      Valid_OUT <= 1'b0;
      if ((r_state == IDLE && !w_memop) || w_done) begin
        r_state           <= IDLE;
        Valid_OUT         <= 1'b1;
        Instr_OUT         <= Instr_IN;
        Instr_PC_OUT      <= Instr_PC_IN;
        WriteRegister_OUT <= WriteRegister_IN;
        Instr_UID_OUT     <= Instr_UID_IN;
        if (r_state == IDLE) begin
          WriteData_OUT <= ALU_result_IN;
          RegWrite_OUT  <= RegWrite_IN;
        end else begin
          WriteData_OUT <= w_ld_done ? f_load(ALU_Control_IN, w_lane, dc.DC_RDATA) : 32'd0;
          RegWrite_OUT  <= w_ld_done & RegWrite_IN;
        end
      end else if (r_state == IDLE) begin
        r_state <= REQ;
      end else if (w_in_req && dc.DC_GNT) begin
        r_state <= WAIT;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a small cache responder and hand-computed results.
module tb_mem_access_stage;
  logic        CLK;
  logic        RESET;
  logic [31:0] Instr_IN, Instr_PC_IN, ALU_result_IN, MemWriteData_IN, Instr_UID_IN;
  logic [5:0]  WriteRegister_IN, ALU_Control_IN;
  logic        RegWrite_IN, MemRead_IN, MemWrite_IN;
  logic        STALL_OUT, READ_COMPLETE, RegWrite_OUT, Valid_OUT, MEM_ERR;
  logic [31:0] Instr_OUT, Instr_PC_OUT, WriteData_OUT, Instr_UID_OUT;
  logic [5:0]  WriteRegister_OUT;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [5:0] LB = 6'b101000, LBU = 6'b101001, LH = 6'b101010,
                         LHU = 6'b101011, SB = 6'b101100, SH = 6'b101101,
                         ADD = 6'b100000, WRD = 6'b000000;

  mem_access_stage_if dc_bus ();

`ifdef MEM_TIMEOUT_EN
  mem_access_stage #(.TIMEOUT_CYCLES(8)) dut (
`else
  mem_access_stage dut (
`endif
    .CLK(CLK), .RESET(RESET),
    .Instr_IN(Instr_IN), .Instr_PC_IN(Instr_PC_IN), .ALU_result_IN(ALU_result_IN),
    .WriteRegister_IN(WriteRegister_IN), .MemWriteData_IN(MemWriteData_IN),
    .RegWrite_IN(RegWrite_IN), .MemRead_IN(MemRead_IN), .MemWrite_IN(MemWrite_IN),
    .ALU_Control_IN(ALU_Control_IN), .Instr_UID_IN(Instr_UID_IN),
    .STALL_OUT(STALL_OUT), .READ_COMPLETE(READ_COMPLETE), .dc(dc_bus),
    .Instr_OUT(Instr_OUT), .Instr_PC_OUT(Instr_PC_OUT), .WriteData_OUT(WriteData_OUT),
    .WriteRegister_OUT(WriteRegister_OUT), .RegWrite_OUT(RegWrite_OUT),
    .Valid_OUT(Valid_OUT), .Instr_UID_OUT(Instr_UID_OUT), .MEM_ERR(MEM_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic mr, input logic mw, input logic rw,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [5:0] wr,
                       input logic [31:0] uid);
    ALU_Control_IN   = op;
    MemRead_IN       = mr;
    MemWrite_IN      = mw;
    RegWrite_IN      = rw;
    ALU_result_IN    = addr;
    MemWriteData_IN  = wd;
    WriteRegister_IN = wr;
    Instr_UID_IN     = uid;
    Instr_IN         = uid ^ 32'hA5A5_0000;
    Instr_PC_IN      = uid << 2;
  endtask

  // Cache responder: grants after gnt_wait request cycles, returns data rv_wait cycles after grant.
  task automatic do_access(input int gnt_wait, input int rv_wait, input logic [31:0] rdata,
                           output int stalls, output int rcs, output int reqs,
                           output logic [31:0] addr, output logic [31:0] wdata,
                           output logic [3:0] be, output logic we);
    int req_cyc, wait_cyc;
    bit waiting, done;
    stalls = 0; rcs = 0; reqs = 0; req_cyc = 0; wait_cyc = 0; waiting = 0; done = 0;
    addr = '0; wdata = '0; be = '0; we = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      dc_bus.DC_GNT    = dc_bus.DC_REQ && (req_cyc >= gnt_wait);
      dc_bus.DC_RVALID = waiting && (wait_cyc >= rv_wait);
      dc_bus.DC_RDATA  = dc_bus.DC_RVALID ? rdata : 32'hDEAD_BEEF;
      #1;
      if (dc_bus.DC_REQ) begin
        reqs++; req_cyc++;
        addr = dc_bus.DC_ADDR; wdata = dc_bus.DC_WDATA; be = dc_bus.DC_BE; we = dc_bus.DC_WE;
      end
      if (STALL_OUT) stalls++;
      if (READ_COMPLETE) begin rcs++; done = 1; end
      if (waiting) wait_cyc++;
      if (dc_bus.DC_REQ && dc_bus.DC_GNT && !dc_bus.DC_WE) waiting = 1;
      @(negedge CLK);
      dc_bus.DC_GNT = 1'b0; dc_bus.DC_RVALID = 1'b0;
    end
    if (!done) chk("access_never_completed", 32'd0, 32'd1);
  endtask

  task automatic load_case(input string tag, input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd, input logic [31:0] uid);
    int st, rc, rq;
    logic [31:0] a, w;
    logic [3:0] b;
    logic we;
    drive(op, 1'b1, 1'b0, 1'b1, addr, 32'h0, 6'd7, uid);
    do_access(0, 0, rdata, st, rc, rq, a, w, b, we);
    chk({tag, "_be"}, {28'd0, b}, {28'd0, exp_be});
    chk({tag, "_data"}, WriteData_OUT, exp_wd);
    chk({tag, "_valid"}, {31'd0, Valid_OUT}, 32'd1);
  endtask

  initial begin
    int st, rc, rq;
    logic [31:0] a, w;
    logic [3:0] b;
    logic we;

    RESET = 1'b0;
    drive(6'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 6'd0, 32'd0);
    dc_bus.DC_GNT = 1'b0; dc_bus.DC_RVALID = 1'b0; dc_bus.DC_RDATA = 32'd0;
    repeat (2) @(negedge CLK);
    chk("rst_valid", {31'd0, Valid_OUT}, 32'd0);
    chk("rst_wdata", WriteData_OUT, 32'd0);
    chk("rst_stall", {31'd0, STALL_OUT}, 32'd0);
    chk("rst_dcreq", {31'd0, dc_bus.DC_REQ}, 32'd0);
    chk("rst_memerr", {31'd0, MEM_ERR}, 32'd0);
    RESET = 1'b1;

    // ALU pass-through
    drive(ADD, 1'b0, 1'b0, 1'b1, 32'h0000_0042, 32'h0, 6'd5, 32'd1);
    #1 chk("alu_stall", {31'd0, STALL_OUT}, 32'd0);
    @(negedge CLK);
    chk("alu_valid", {31'd0, Valid_OUT}, 32'd1);
    chk("alu_data", WriteData_OUT, 32'h42);
    chk("alu_wreg", {26'd0, WriteRegister_OUT}, 32'd5);
    chk("alu_uid", Instr_UID_OUT, 32'd1);
    chk("alu_pc", Instr_PC_OUT, 32'd4);
    chk("alu_instr", Instr_OUT, 32'hA5A5_0001);

    // LB with delayed grant
    drive(LB, 1'b1, 1'b0, 1'b1, 32'h0000_1003, 32'h0, 6'd7, 32'd2);
    do_access(2, 0, 32'h1122_3380, st, rc, rq, a, w, b, we);
    chk("lb_stall_cycles", st, 4);
    chk("lb_rc_pulses", rc, 1);
    chk("lb_addr", a, 32'h0000_1000);
    chk("lb_be", {28'd0, b}, 32'h1);
    chk("lb_data", WriteData_OUT, 32'hFFFF_FF80);
    chk("lb_regwrite", {31'd0, RegWrite_OUT}, 32'd1);
    chk("lb_uid", Instr_UID_OUT, 32'd2);
    #1 chk("lb_rc_after", {31'd0, READ_COMPLETE}, 32'd0);

    load_case("lbu", LBU, 32'h0000_1003, 32'h1122_3380, 4'b0001, 32'h0000_0080, 32'd3);
    load_case("lh", LH, 32'h0000_1002, 32'h1234_8001, 4'b0011, 32'hFFFF_8001, 32'd4);
    load_case("lhu", LHU, 32'h0000_1001, 32'hABCD_0000, 4'b1100, 32'h0000_ABCD, 32'd5);
    load_case("lb_lane1", LB, 32'h0000_0005, 32'h117F_2233, 4'b0100, 32'h0000_007F, 32'd6);

    // SH with immediate grant
    drive(SH, 1'b0, 1'b1, 1'b1, 32'h0000_2002, 32'h0000_BEEF, 6'd9, 32'd7);
    do_access(0, 0, 32'h0, st, rc, rq, a, w, b, we);
    chk("sh_stall_cycles", st, 1);
    chk("sh_req_cycles", rq, 1);
    chk("sh_be", {28'd0, b}, 32'h3);
    chk("sh_wdata", w, 32'hBEEF_BEEF);
    chk("sh_we", {31'd0, we}, 32'd1);
    chk("sh_regwrite", {31'd0, RegWrite_OUT}, 32'd0);
    chk("sh_data", WriteData_OUT, 32'd0);
    chk("sh_valid", {31'd0, Valid_OUT}, 32'd1);

    drive(SB, 1'b0, 1'b1, 1'b0, 32'h0000_0001, 32'h1234_56A5, 6'd0, 32'd8);
    do_access(1, 0, 32'h0, st, rc, rq, a, w, b, we);
    chk("sb_be", {28'd0, b}, 32'h4);
    chk("sb_wdata", w, 32'hA5A5_A5A5);

    drive(WRD, 1'b0, 1'b1, 1'b0, 32'h0000_0043, 32'h0102_0304, 6'd0, 32'd9);
    do_access(0, 0, 32'h0, st, rc, rq, a, w, b, we);
    chk("sw_be", {28'd0, b}, 32'hF);
    chk("sw_addr", a, 32'h0000_0040);
    chk("sw_wdata", w, 32'h0102_0304);

    // MemRead and MemWrite both set behave as a load
    drive(WRD, 1'b1, 1'b1, 1'b1, 32'h0000_0050, 32'h0, 6'd3, 32'd10);
    do_access(0, 0, 32'h600D_F00D, st, rc, rq, a, w, b, we);
    chk("rdwr_we", {31'd0, we}, 32'd0);
    chk("rdwr_data", WriteData_OUT, 32'h600D_F00D);

    // LW then ADD back to back
    drive(WRD, 1'b1, 1'b0, 1'b1, 32'h0000_3000, 32'h0, 6'd10, 32'd20);
    do_access(1, 2, 32'hCAFE_BABE, st, rc, rq, a, w, b, we);
    chk("lw_data", WriteData_OUT, 32'hCAFE_BABE);
    chk("lw_uid", Instr_UID_OUT, 32'd20);
    drive(ADD, 1'b0, 1'b0, 1'b1, 32'h0000_0077, 32'h0, 6'd11, 32'd21);
    @(negedge CLK);
    chk("add_valid", {31'd0, Valid_OUT}, 32'd1);
    chk("add_uid", Instr_UID_OUT, 32'd21);
    chk("add_data", WriteData_OUT, 32'h77);

    // Reset in the middle of an access
    drive(WRD, 1'b1, 1'b0, 1'b1, 32'h0000_4000, 32'h0, 6'd12, 32'd30);
    repeat (3) @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    chk("mid_rst_dcreq", {31'd0, dc_bus.DC_REQ}, 32'd0);
    chk("mid_rst_stall", {31'd0, STALL_OUT}, 32'd0);
    chk("mid_rst_wdata", WriteData_OUT, 32'd0);
    chk("mid_rst_uid", Instr_UID_OUT, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    dc_bus.DC_RVALID = 1'b1; dc_bus.DC_RDATA = 32'h1234_5678;
    @(negedge CLK);
    dc_bus.DC_RVALID = 1'b0;
    chk("late_rvalid_valid", {31'd0, Valid_OUT}, 32'd0);
    chk("late_rvalid_req", {31'd0, dc_bus.DC_REQ}, 32'd1);
    do_access(0, 0, 32'h0000_0055, st, rc, rq, a, w, b, we);
    chk("after_rst_data", WriteData_OUT, 32'h55);
    chk("after_rst_uid", Instr_UID_OUT, 32'd30);

`ifdef MEM_TIMEOUT_EN
    drive(WRD, 1'b1, 1'b0, 1'b1, 32'h0000_5000, 32'h0, 6'd13, 32'd40);
    do_access(1000, 0, 32'h0, st, rc, rq, a, w, b, we);
    chk("to_req_cycles", rq, 8);
    chk("to_rc_pulses", rc, 1);
    chk("to_err", {31'd0, MEM_ERR}, 32'd1);
    chk("to_data", WriteData_OUT, 32'd0);
    chk("to_regwrite", {31'd0, RegWrite_OUT}, 32'd0);
    chk("to_valid", {31'd0, Valid_OUT}, 32'd1);
    drive(ADD, 1'b0, 1'b0, 1'b1, 32'h1, 32'h0, 6'd1, 32'd41);
    repeat (2) @(negedge CLK);
    chk("to_err_sticky", {31'd0, MEM_ERR}, 32'd1);
`else
    chk("no_timeout_err", {31'd0, MEM_ERR}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
